// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants, divider width.
package uart_pkg;

  typedef enum logic [1:0] {
    Idle,
    Start,
    Data,
    Stop
  } uart_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SCNT_W     = $clog2(OVERSAMPLE);
  localparam int unsigned DIV_W      = 11;

  localparam logic [SCNT_W-1:0] MID_SAMPLE  = SCNT_W'(7);
  localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(15);

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversampling tick generator, common to the UART TX and RX sides.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, centre sampling and framing-error detection.
// Build option: UART_RX_MAJORITY_EN selects 3-tick majority voting for each bit decision.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] div_i,
  input  logic             rx_i,
  output logic [7:0]       data_o,
  output logic             rx_valid_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  logic tick;

  uart_baud_gen u_baud_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .div_i  (div_i),
    .tick_o (tick)
  );

  // Synchroniser and edge detector, preset to the idle-high line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rx_s;
  logic                   fall;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rx_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= rx_s;
    end
  end

  logic bit_b;

`ifdef UART_RX_MAJORITY_EN
  // Only the two older samples are stored; the current one completes the window.
  logic [1:0] hist_q, hist_d;
  logic [2:0] window;

  assign window = {hist_q, rx_s};
  assign bit_b  = majority3(window);

  always_comb begin
    hist_d = hist_q;
    if (tick) hist_d = window[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) hist_q <= '1;
    else         hist_q <= hist_d;
  end
`else
  assign bit_b = rx_s;
`endif

  uart_state_t       state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      Idle: begin
        if (fall) begin
          state_d = Start;
          scnt_d  = '0;
        end
      end
      Start: begin
        if (tick) begin
          if (scnt_q == MID_SAMPLE) begin
            scnt_d = '0;
            if (bit_b) begin
              state_d = Idle;
            end else begin
              state_d = Data;
              bcnt_d  = '0;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      Data: begin
        if (tick) begin
          if (scnt_q == LAST_SAMPLE) begin
            shift_d = {bit_b, shift_q[7:1]};
            scnt_d  = '0;
            if (bcnt_q == 3'd7) state_d = Stop;
            else                bcnt_d  = bcnt_q + 1'b1;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      Stop: begin
        if (tick) begin
          if (scnt_q == LAST_SAMPLE) begin
            data_d  = shift_q;
            valid_d = bit_b;
            ferr_d  = ~bit_b;
            scnt_d  = '0;
            state_d = Idle;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Idle;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != Idle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor checks each pulse.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [10:0] div_i = '0;
  logic        rx_i = 1'b1;
  logic [7:0]  data_o;
  logic        rx_valid_o;
  logic        frame_err_o;
  logic        busy_o;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .div_i       (div_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .rx_valid_o  (rx_valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_i = v;
    step(n);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    int bt;
    bt = 16 * (int'(div_i) + 1);
    drive(1'b0, bt);
    for (int i = 0; i < 8; i++) drive(b[i], bt);
    drive(stop, bt);
    rx_i = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic ferr);
    exp_t e;
    e.ferr = ferr;
    e.data = b;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin
      step(1);
      n++;
    end
    chk(name, 32'(busy_o), 32'd0);
  endtask

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && (rx_valid_o || frame_err_o)) begin
      chk("pulse_exclusive", 32'(rx_valid_o & frame_err_o), 32'd0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%0h, nothing expected",
                 rx_valid_o, frame_err_o, data_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_kind_ferr", 32'(frame_err_o), 32'(e.ferr));
        chk("pulse_data", 32'(data_o), 32'(e.data));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    rx_i   = 1'b1;
    div_i  = 11'd0;
    step(4);
    chk("reset_data", 32'(data_o), 32'h0);
    chk("reset_valid", 32'(rx_valid_o), 32'd0);
    chk("reset_ferr", 32'(frame_err_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    step(8);

    // Good byte at 16 clocks per bit.
    expect_byte(8'hA5, 1'b0);
    send(8'hA5, 1'b1);
    step(8);
    wait_idle("t1_idle", 64);
    step(20);

    // Start glitch: low for 4 ticks, rejected at the start-bit centre.
    drive(1'b0, 4);
    chk("t2_busy_high", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    wait_idle("t2_idle_within_8", 8);
    chk("t2_data_kept", 32'(data_o), 32'hA5);
    step(20);

    // One-clock inversion exactly at the bit-2 decision of 0x00.
    expect_byte(GLITCH_EXP, 1'b0);
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b0, 8);
    drive(1'b1, 1);
    drive(1'b0, 7);
    for (int i = 3; i < 8; i++) drive(1'b0, 16);
    drive(1'b1, 16);
    step(8);
    wait_idle("t6_idle", 64);
    step(20);

    // Framing error followed by a 40-bit break.
    expect_byte(8'h3C, 1'b1);
    send(8'h3C, 1'b0);
    drive(1'b0, 40 * 16);
    chk("t3_break_idle", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    step(40);

    // Back-to-back frames with a slower divider.
    div_i = 11'd3;
    step(8);
    expect_byte(8'h00, 1'b0);
    expect_byte(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    step(32);
    wait_idle("t4_idle", 200);
    step(40);

    // Reset in the middle of data bit 4 of 0x55, then a clean 0x81.
    drive(1'b0, 64);
    drive(1'b1, 64);
    drive(1'b0, 64);
    drive(1'b1, 64);
    drive(1'b0, 64);
    drive(1'b1, 32);
    chk("t5_busy_before_reset", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    step(3);
    chk("t5_reset_data", 32'(data_o), 32'h0);
    chk("t5_reset_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    step(64);
    chk("t5_idle_after_reset", 32'(busy_o), 32'd0);
    expect_byte(8'h81, 1'b0);
    send(8'h81, 1'b1);
    step(32);
    wait_idle("t5_idle", 200);
    step(40);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: got %0d outstanding expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
